// File: rtl/data_acc_pkg.sv
// rtl/data_acc_pkg.sv - shared widths and state encoding for the data accumulator controller
package data_acc_pkg;

  localparam int ACC_DATA_WIDTH = 16;
  localparam int COH_WIDTH      = 10;
  localparam int SMP_WIDTH      = 8;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    ACC,
    SAVE
  } state_t;

endpackage

// File: rtl/data_acc_ctrl_if.sv
// rtl/data_acc_ctrl_if.sv - scheduler, accumulator and state-buffer signals of the controller
interface data_acc_ctrl_if import data_acc_pkg::*; #(
  parameter int ACC_DATA_WIDTH = data_acc_pkg::ACC_DATA_WIDTH,
  parameter int COH_WIDTH      = data_acc_pkg::COH_WIDTH,
  parameter int SMP_WIDTH      = data_acc_pkg::SMP_WIDTH
) ();

  logic                      start;
  logic [SMP_WIDTH-1:0]      sample_num;
  logic [COH_WIDTH-1:0]      coh_len;
  logic [COH_WIDTH-1:0]      coh_cnt_i;
  logic [ACC_DATA_WIDTH-1:0] i_acc_o;
  logic [ACC_DATA_WIDTH-1:0] q_acc_o;
  logic                      acc_in_en;
  logic                      acc_clear;
  logic                      acc_active;
  logic                      state_wr;
  logic [COH_WIDTH-1:0]      coh_cnt_o;
  logic                      dump_valid;
  logic [ACC_DATA_WIDTH-1:0] dump_i;
  logic [ACC_DATA_WIDTH-1:0] dump_q;
  logic                      busy;
  logic                      done;

  modport master (
    output start, sample_num, coh_len, coh_cnt_i, i_acc_o, q_acc_o,
    input  acc_in_en, acc_clear, acc_active, state_wr, coh_cnt_o,
           dump_valid, dump_i, dump_q, busy, done
  );

  modport slave (
    input  start, sample_num, coh_len, coh_cnt_i, i_acc_o, q_acc_o,
    output acc_in_en, acc_clear, acc_active, state_wr, coh_cnt_o,
           dump_valid, dump_i, dump_q, busy, done
  );

endinterface

// File: rtl/data_acc_ctrl_coh_cnt_gen.sv
// rtl/data_acc_ctrl_coh_cnt_gen.sv - coherent-period counter with clear and dump-pending generation
module coh_cnt_gen import data_acc_pkg::*; #(
  parameter int COH_WIDTH = data_acc_pkg::COH_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic                 load,
  input  logic [COH_WIDTH-1:0] coh_len,
  input  logic [COH_WIDTH-1:0] coh_cnt_i,
  input  logic                 adv,
  output logic [COH_WIDTH-1:0] coh_cnt,
  output logic                 acc_clear,
  output logic                 dump_pend
);

  logic [COH_WIDTH-1:0] len_q;
  logic [COH_WIDTH-1:0] cnt_q;
  logic                 pend_q;
  logic [COH_WIDTH-1:0] len_eff;
  logic                 wrap;

  // A zero length would never wrap; run it as a one-sample period instead.
  assign len_eff = (coh_len == '0) ? COH_WIDTH'(1) : coh_len;
  assign wrap    = (cnt_q == len_q - COH_WIDTH'(1));

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      len_q  <= COH_WIDTH'(1);
      cnt_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      if (load) begin
        len_q <= len_eff;
        cnt_q <= (coh_cnt_i >= len_eff) ? '0 : coh_cnt_i;
      end else if (adv) begin
        cnt_q <= wrap ? '0 : cnt_q + COH_WIDTH'(1);
      end
      pend_q <= adv && wrap;
    end
  end

  assign coh_cnt   = cnt_q;
  assign acc_clear = adv && (cnt_q == '0);
  assign dump_pend = pend_q;

endmodule

// File: rtl/data_acc_ctrl.sv
// rtl/data_acc_ctrl.sv - sequences one I/Q accumulator through a time-slot block: load, accumulate, dump, save
module data_acc_ctrl import data_acc_pkg::*; #(
  parameter int ACC_DATA_WIDTH = data_acc_pkg::ACC_DATA_WIDTH,
  parameter int COH_WIDTH      = data_acc_pkg::COH_WIDTH,
  parameter int SMP_WIDTH      = data_acc_pkg::SMP_WIDTH
) (
  input  logic           clk,
  input  logic           rst_b,
  data_acc_ctrl_if.slave bus
);

  state_t                    state_q;
  state_t                    state_d;
  logic [SMP_WIDTH-1:0]      smp_num_q;
  logic [SMP_WIDTH-1:0]      smp_cnt_q;
  logic [ACC_DATA_WIDTH-1:0] dump_i_q;
  logic [ACC_DATA_WIDTH-1:0] dump_q_q;
  logic                      dump_valid_q;
  logic                      start_ok;
  logic                      in_acc;
  logic                      acc_clear;
  logic                      dump_pend;
  logic [COH_WIDTH-1:0]      coh_cnt;

  assign start_ok = (state_q == IDLE) && bus.start;
  assign in_acc   = (state_q == ACC);

  coh_cnt_gen #(.COH_WIDTH(COH_WIDTH)) u_coh_cnt_gen (
    .clk       (clk),
    .rst_b     (rst_b),
    .load      (start_ok),
    .coh_len   (bus.coh_len),
    .coh_cnt_i (bus.coh_cnt_i),
    .adv       (in_acc),
    .coh_cnt   (coh_cnt),
    .acc_clear (acc_clear),
    .dump_pend (dump_pend)
  );

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.start) state_d = LOAD;
      LOAD: state_d = (smp_num_q != '0) ? ACC : SAVE;
      ACC:  if (smp_cnt_q == smp_num_q - SMP_WIDTH'(1)) state_d = SAVE;
      SAVE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Dump registers are only touched by a pending dump, so a back-to-back LOAD leaves them intact.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      smp_num_q    <= '0;
      smp_cnt_q    <= '0;
      dump_i_q     <= '0;
      dump_q_q     <= '0;
      dump_valid_q <= 1'b0;
    end else begin
      if (start_ok) begin
        smp_num_q <= bus.sample_num;
        smp_cnt_q <= '0;
      end else if (in_acc) begin
        smp_cnt_q <= smp_cnt_q + SMP_WIDTH'(1);
      end
      if (dump_pend) begin
        dump_i_q <= bus.i_acc_o;
        dump_q_q <= bus.q_acc_o;
      end
      dump_valid_q <= dump_pend;
    end
  end

  assign bus.acc_in_en  = (state_q == LOAD);
  assign bus.acc_active = in_acc;
  assign bus.acc_clear  = acc_clear;
  assign bus.state_wr   = (state_q == SAVE);
  assign bus.done       = (state_q == SAVE);
  assign bus.coh_cnt_o  = coh_cnt;
  assign bus.busy       = (state_q != IDLE);
  assign bus.dump_valid = dump_valid_q;
  assign bus.dump_i     = dump_i_q;
  assign bus.dump_q     = dump_q_q;

endmodule

// File: tb/tb_data_acc_ctrl.sv
// tb/tb_data_acc_ctrl.sv - table-driven and hand-sequenced checks of data_acc_ctrl
module tb_data_acc_ctrl;
  import data_acc_pkg::*;

  typedef struct {
    int          smp;
    int          clen;
    int          ccnt;
    int          li;
    int          lq;
    int          si;
    int          sq;
    int          ndump;
    int          d0i;
    int          d0q;
    int          dli;
    int          dlq;
    int          svi;
    int          svq;
    int          cco;
    logic [15:0] cmask;
    int          poke;
  } vec_t;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  data_acc_ctrl_if bus ();

  data_acc_ctrl dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
  );

  // Environment accumulator: loads saved sums, adds one sample per active cycle.
  logic signed [15:0] m_i, m_q, ld_i, ld_q, cur_si, cur_sq;
  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      m_i <= '0;
      m_q <= '0;
    end else if (bus.acc_in_en) begin
      m_i <= ld_i;
      m_q <= ld_q;
    end else if (bus.acc_active) begin
      m_i <= (bus.acc_clear ? 16'sd0 : m_i) + cur_si;
      m_q <= (bus.acc_clear ? 16'sd0 : m_q) + cur_sq;
    end
  end
  assign bus.i_acc_o = m_i;
  assign bus.q_acc_o = m_q;

  int done_cnt = 0;
  always @(posedge clk) if (bus.done) done_cnt <= done_cnt + 1;

  int checks = 0;
  int errors = 0;
  vec_t vecs[7];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_block(input vec_t v, input int idx);
    int k_done = 0;
    int ndump = 0;
    int base;
    logic [15:0] mask = '0;
    longint fi = 0, fq = 0, lsti = 0, lstq = 0, svi = 0, svq = 0, cco = 0;
    logic swr = 1'b0;
    @(negedge clk);
    bus.sample_num = 8'(v.smp);
    bus.coh_len    = 10'(v.clen);
    bus.coh_cnt_i  = 10'(v.ccnt);
    ld_i = 16'(v.li);
    ld_q = 16'(v.lq);
    cur_si = 16'(v.si);
    cur_sq = 16'(v.sq);
    bus.start = 1'b1;
    base = done_cnt;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      bus.start = (k == v.poke);
      if (k == 1) chk($sformatf("v%0d_load_en", idx), longint'(bus.acc_in_en), 1);
      if (bus.acc_clear && k >= 2 && k < 18) mask[k-2] = 1'b1;
      if (bus.dump_valid) begin
        if (ndump == 0) begin
          fi = longint'($signed(bus.dump_i));
          fq = longint'($signed(bus.dump_q));
        end
        lsti = longint'($signed(bus.dump_i));
        lstq = longint'($signed(bus.dump_q));
        ndump++;
      end
      if (bus.done && k_done == 0) begin
        k_done = k;
        svi = longint'($signed(bus.i_acc_o));
        svq = longint'($signed(bus.q_acc_o));
        cco = longint'(bus.coh_cnt_o);
        swr = bus.state_wr;
      end
      if (k_done != 0 && k == k_done + 2) break;
    end
    bus.start = 1'b0;
    chk($sformatf("v%0d_done_cycle", idx), k_done, v.smp + 2);
    chk($sformatf("v%0d_state_wr", idx), longint'(swr), 1);
    chk($sformatf("v%0d_ndump", idx), ndump, v.ndump);
    if (v.ndump > 0) begin
      chk($sformatf("v%0d_first_dump_i", idx), fi, v.d0i);
      chk($sformatf("v%0d_first_dump_q", idx), fq, v.d0q);
      chk($sformatf("v%0d_last_dump_i", idx), lsti, v.dli);
      chk($sformatf("v%0d_last_dump_q", idx), lstq, v.dlq);
    end
    chk($sformatf("v%0d_save_i", idx), svi, v.svi);
    chk($sformatf("v%0d_save_q", idx), svq, v.svq);
    chk($sformatf("v%0d_coh_cnt_o", idx), cco, v.cco);
    chk($sformatf("v%0d_clear_mask", idx), longint'(mask), longint'(v.cmask));
    chk($sformatf("v%0d_done_count", idx), done_cnt - base, 1);
    chk($sformatf("v%0d_idle_after", idx), longint'(bus.busy), 0);
  endtask

  initial begin
    int base;
    bus.start = 1'b0;
    bus.sample_num = '0;
    bus.coh_len = '0;
    bus.coh_cnt_i = '0;
    ld_i = '0; ld_q = '0; cur_si = '0; cur_sq = '0;

    vecs[0] = '{10, 4, 0, 100, 50, 1, -1, 2, 4, -4, 4, -4, 2, -2, 2, 16'h0111, 0};
    vecs[1] = '{3, 4, 2, 2, -2, 1, -1, 1, 4, -4, 4, -4, 1, -1, 1, 16'h0004, 0};
    vecs[2] = '{3, 1, 0, 7, 0, -3, 5, 3, -3, 5, -3, 5, -3, 5, 0, 16'h0007, 0};
    vecs[3] = '{4, 4, 0, 9, 9, 2, 3, 1, 8, 12, 8, 12, 8, 12, 0, 16'h0001, 0};
    vecs[4] = '{0, 5, 7, 11, 22, 0, 0, 0, 0, 0, 0, 0, 11, 22, 0, 16'h0000, 0};
    vecs[5] = '{5, 3, 1, 10, 0, 1, 1, 2, 12, 2, 3, 3, 3, 3, 0, 16'h0004, 3};
    vecs[6] = '{2, 0, 3, 5, 5, 4, -4, 2, 4, -4, 4, -4, 4, -4, 0, 16'h0003, 4};

    repeat (2) @(negedge clk);
    chk("rst_busy", longint'(bus.busy), 0);
    chk("rst_strobes", longint'({bus.acc_in_en, bus.acc_clear, bus.acc_active, bus.state_wr, bus.done, bus.dump_valid}), 0);
    chk("rst_dump_i", longint'(bus.dump_i), 0);
    chk("rst_coh_cnt_o", longint'(bus.coh_cnt_o), 0);
    rst_b = 1'b1;

    for (int i = 0; i < 7; i++) run_block(vecs[i], i);

    // Boundary on last sample, then a start in the IDLE cycle carrying the pipelined dump.
    @(negedge clk);
    bus.sample_num = 8'd4; bus.coh_len = 10'd4; bus.coh_cnt_i = 10'd0;
    ld_i = 16'sd0; ld_q = 16'sd0; cur_si = 16'sd2; cur_sq = 16'sd1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    chk("b2b_save_done", longint'(bus.done), 1);
    @(negedge clk);
    chk("b2b_dump_valid", longint'(bus.dump_valid), 1);
    chk("b2b_dump_i", longint'($signed(bus.dump_i)), 8);
    chk("b2b_dump_q", longint'($signed(bus.dump_q)), 4);
    chk("b2b_idle", longint'(bus.busy), 0);
    bus.sample_num = 8'd0; ld_i = 16'sd77; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("b2b_load", longint'(bus.acc_in_en), 1);
    chk("b2b_dump_held", longint'($signed(bus.dump_i)), 8);
    chk("b2b_dump_valid_off", longint'(bus.dump_valid), 0);
    @(negedge clk);
    chk("b2b_second_done", longint'(bus.done), 1);
    @(negedge clk);
    chk("b2b_final_idle", longint'(bus.busy), 0);

    // Reset in the middle of accumulation.
    bus.sample_num = 8'd10; bus.coh_len = 10'd4; bus.coh_cnt_i = 10'd0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_in_acc", longint'(bus.acc_active), 1);
    rst_b = 1'b0;
    #1;
    chk("abort_busy", longint'(bus.busy), 0);
    chk("abort_strobes", longint'({bus.acc_in_en, bus.acc_clear, bus.acc_active, bus.state_wr, bus.done, bus.dump_valid}), 0);
    chk("abort_dump", longint'({bus.dump_i, bus.dump_q}), 0);
    chk("abort_coh_cnt_o", longint'(bus.coh_cnt_o), 0);
    base = done_cnt;
    repeat (3) @(negedge clk);
    rst_b = 1'b1;
    repeat (15) @(negedge clk);
    chk("abort_no_done", done_cnt - base, 0);
    chk("abort_stays_idle", longint'(bus.busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
